// File: rtl/task_clk_sequencer_if.sv
// Bundle between the debug host / wrappers and the task clock sequencer.
// Inputs come from the host registers and the task-interruption wrappers.
// Outputs drive the BUFGCE enable, the wrapper stop ports and status flags.
//
// Stop handshake: stop_req and stop_ack form a four-phase level handshake per
// wrapper. The sequencer raises stop_req for every wrapper and holds it until
// all stop_ack bits are high. It then drops stop_req and waits until all
// stop_ack bits are low again. Either wait is bounded by ACK_TIMEOUT cycles.
// Reset may drop stop_req at any point, without completing the handshake.
interface task_clk_sequencer_if #(
  parameter int NUM_TI_WRAPPERS = 1,
  parameter int CNT_W           = 32
);
  logic                       run_en;
  logic                       step_req;
  logic [CNT_W-1:0]           breakpoint;
  logic                       ti_req;
  logic                       pr_done;
  logic [NUM_TI_WRAPPERS-1:0] stop_ack;
  logic                       task_clk_ce;
  logic [NUM_TI_WRAPPERS-1:0] stop_req;
  logic                       decouple;
  logic                       ti_gnt;
  logic                       busy;
  logic                       break_hit;
  logic                       timeout_err;
  logic [CNT_W-1:0]           cycle_count;
  logic [2:0]                 state_dbg;

  modport master (
    output run_en, step_req, breakpoint, ti_req, pr_done, stop_ack,
    input  task_clk_ce, stop_req, decouple, ti_gnt, busy, break_hit,
           timeout_err, cycle_count, state_dbg
  );

  modport slave (
    input  run_en, step_req, breakpoint, ti_req, pr_done, stop_ack,
    output task_clk_ce, stop_req, decouple, ti_gnt, busy, break_hit,
           timeout_err, cycle_count, state_dbg
  );
endinterface

// File: rtl/task_clk_sequencer.sv
// Task clock sequencer: gates the task clock (free-run or single-step), stops
// on a cycle-count breakpoint or an interruption request, and sequences the
// stop / decouple / reconfigure / release handshake with the TI wrappers.
// Every output is a register written in the same edge as the state.
module task_clk_sequencer #(
  parameter int NUM_TI_WRAPPERS = 1,
  parameter int CNT_W           = 32,
  parameter int ACK_TIMEOUT     = 1024
) (
  input logic                  sys_clk,
  input logic                  sys_reset_n,
  task_clk_sequencer_if.slave  bus
);

  localparam int TO_W = $clog2(ACK_TIMEOUT);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_STEP      = 3'd2,
    S_STOP      = 3'd3,
    S_DECOUPLED = 3'd4,
    S_RELEASE   = 3'd5
  } state_t;

  state_t                     state_q;
  logic                       step_req_q;
  logic [TO_W-1:0]            to_cnt_q;
  logic                       ce_q;
  logic [NUM_TI_WRAPPERS-1:0] stop_req_q;
  logic                       decouple_q;
  logic                       ti_gnt_q;
  logic                       busy_q;
  logic                       break_hit_q;
  logic                       timeout_err_q;
  logic [CNT_W-1:0]           cycle_count_q;

  logic step_edge;
  logic bp_hit;
  logic all_acked;
  logic none_acked;

  // An all-ones breakpoint is the "disabled" encoding and never matches.
  assign step_edge  = bus.step_req & ~step_req_q;
  assign bp_hit     = (cycle_count_q == bus.breakpoint) & ~(&bus.breakpoint);
  assign all_acked  = &bus.stop_ack;
  assign none_acked = ~(|bus.stop_ack);

  // Sequencer FSM; outputs are set on the edge that enters each state.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q       <= S_IDLE;
      step_req_q    <= 1'b0;
      to_cnt_q      <= '0;
      ce_q          <= 1'b0;
      stop_req_q    <= '0;
      decouple_q    <= 1'b0;
      ti_gnt_q      <= 1'b0;
      busy_q        <= 1'b0;
      break_hit_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      step_req_q <= bus.step_req;
      case (state_q)
        S_IDLE: begin
          if (!bus.run_en) break_hit_q <= 1'b0;
          if (bus.ti_req) begin
            state_q    <= S_STOP;
            stop_req_q <= '1;
            busy_q     <= 1'b1;
            to_cnt_q   <= '0;
          end else if (step_edge) begin
            state_q <= S_STEP;
            ce_q    <= 1'b1;
            busy_q  <= 1'b1;
          end else if (bus.run_en && !break_hit_q) begin
            state_q <= S_RUN;
            ce_q    <= 1'b1;
          end
        end
        S_RUN: begin
          // The cycle that matched the breakpoint was the last one issued,
          // so the count is frozen at the breakpoint value.
          if (bp_hit || bus.ti_req) begin
            state_q    <= S_STOP;
            ce_q       <= 1'b0;
            stop_req_q <= '1;
            busy_q     <= 1'b1;
            to_cnt_q   <= '0;
            if (bp_hit) break_hit_q <= 1'b1;
          end else begin
            cycle_count_q <= cycle_count_q + CNT_ONE;
            if (!bus.run_en) begin
              state_q <= S_IDLE;
              ce_q    <= 1'b0;
            end
          end
        end
        S_STEP: begin
          cycle_count_q <= cycle_count_q + CNT_ONE;
          state_q       <= S_IDLE;
          ce_q          <= 1'b0;
          busy_q        <= 1'b0;
        end
        S_STOP: begin
          if (all_acked) begin
            state_q    <= S_DECOUPLED;
            decouple_q <= 1'b1;
            ti_gnt_q   <= 1'b1;
            to_cnt_q   <= '0;
          end else if (to_cnt_q == TO_LAST) begin
            state_q       <= S_RELEASE;
            stop_req_q    <= '0;
            timeout_err_q <= 1'b1;
            to_cnt_q      <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + TO_ONE;
          end
        end
        S_DECOUPLED: begin
          if (bus.pr_done) begin
            state_q    <= S_RELEASE;
            decouple_q <= 1'b0;
            ti_gnt_q   <= 1'b0;
            stop_req_q <= '0;
            to_cnt_q   <= '0;
          end
        end
        S_RELEASE: begin
          if (none_acked) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (to_cnt_q == TO_LAST) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + TO_ONE;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          ce_q       <= 1'b0;
          stop_req_q <= '0;
          decouple_q <= 1'b0;
          ti_gnt_q   <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.task_clk_ce = ce_q;
  assign bus.stop_req    = stop_req_q;
  assign bus.decouple    = decouple_q;
  assign bus.ti_gnt      = ti_gnt_q;
  assign bus.busy        = busy_q;
  assign bus.break_hit   = break_hit_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.cycle_count = cycle_count_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_task_clk_sequencer.sv
// Bench for task_clk_sequencer: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model of the sequencing rules.
module tb_task_clk_sequencer;

  localparam int NW    = 2;
  localparam int CW    = 4;
  localparam int ACK_T = 8;

  logic clk;
  logic rst_n;

  task_clk_sequencer_if #(.NUM_TI_WRAPPERS(NW), .CNT_W(CW)) bus ();

  task_clk_sequencer #(
    .NUM_TI_WRAPPERS(NW),
    .CNT_W          (CW),
    .ACK_TIMEOUT    (ACK_T)
  ) dut (
    .sys_clk    (clk),
    .sys_reset_n(rst_n),
    .bus        (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // {ce, stop_req[1:0], decouple, ti_gnt, busy, break_hit, timeout_err, cycle_count[3:0]}
  function automatic logic [11:0] dut_vec();
    return {bus.task_clk_ce, bus.stop_req, bus.decouple, bus.ti_gnt, bus.busy,
            bus.break_hit, bus.timeout_err, bus.cycle_count};
  endfunction

  // ---------------- behavioural model ----------------
  // Phases of the sequencing story, tracked at the level of "what the task
  // clock and wrappers are doing", plus the number of cycles spent waiting.
  localparam int P_IDLE = 0, P_FREE = 1, P_ONE = 2, P_HALT = 3, P_HELD = 4, P_DROP = 5;
  int         m_phase;
  int         m_waited;
  logic [3:0] m_cnt;
  logic       m_brk, m_terr, m_prev_step, m_edge;
  logic [11:0] exp_q[$];

  function automatic logic [11:0] model_vec();
    logic ce, held;
    ce   = (m_phase == P_FREE) || (m_phase == P_ONE);
    held = (m_phase == P_HELD);
    return {ce, ((m_phase == P_HALT) || held) ? 2'b11 : 2'b00, held, held,
            (m_phase >= P_ONE), m_brk, m_terr, m_cnt};
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = P_IDLE; m_waited = 0; m_cnt = '0;
        m_brk = 1'b0; m_terr = 1'b0; m_prev_step = 1'b0;
        exp_q.delete();
      end else begin
        m_edge      = bus.step_req && !m_prev_step;
        m_prev_step = bus.step_req;
        case (m_phase)
          P_IDLE: begin
            if (!bus.run_en) m_brk = 1'b0;
            if (bus.ti_req) begin m_phase = P_HALT; m_waited = 0; end
            else if (m_edge) m_phase = P_ONE;
            else if (bus.run_en && !m_brk) m_phase = P_FREE;
          end
          P_FREE: begin
            if (m_cnt == bus.breakpoint && bus.breakpoint != 4'hF) begin
              m_brk = 1'b1; m_phase = P_HALT; m_waited = 0;
            end else if (bus.ti_req) begin
              m_phase = P_HALT; m_waited = 0;
            end else begin
              m_cnt = m_cnt + 4'd1;
              if (!bus.run_en) m_phase = P_IDLE;
            end
          end
          P_ONE: begin m_cnt = m_cnt + 4'd1; m_phase = P_IDLE; end
          P_HALT: begin
            if (bus.stop_ack == 2'b11) m_phase = P_HELD;
            else begin
              m_waited++;
              if (m_waited == ACK_T) begin m_terr = 1'b1; m_phase = P_DROP; m_waited = 0; end
            end
          end
          P_HELD: if (bus.pr_done) begin m_phase = P_DROP; m_waited = 0; end
          P_DROP: begin
            if (bus.stop_ack == 2'b00) m_phase = P_IDLE;
            else begin
              m_waited++;
              if (m_waited == ACK_T) begin m_terr = 1'b1; m_phase = P_IDLE; end
            end
          end
          default: m_phase = P_IDLE;
        endcase
        exp_q.push_back(model_vec());
      end
    end
  end

  // ---------------- scoreboard: one compare per cycle ----------------
  initial begin
    logic [11:0] exp_v;
    forever begin
      @(negedge clk);
      exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 12'h000;
      check("cycle_model", 32'(dut_vec()), 32'(exp_v));
    end
  end

  // ---------------- monitor counters ----------------
  int ce_total = 0, stop_total = 0, dec_total = 0, wrap_total = 0;
  initial begin
    logic [3:0] prev_cnt;
    prev_cnt = '0;
    forever begin
      @(negedge clk);
      if (bus.task_clk_ce) ce_total++;
      if (bus.stop_req == 2'b11) stop_total++;
      if (bus.decouple) dec_total++;
      if (prev_cnt == 4'hF && bus.cycle_count == 4'h0 && rst_n) wrap_total++;
      prev_cnt = bus.cycle_count;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.run_en = 1'b0; bus.step_req = 1'b0; bus.ti_req = 1'b0;
    bus.pr_done = 1'b0; bus.stop_ack = '0; bus.breakpoint = 4'hF;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic at_drive_point();
    @(posedge clk); #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base_ce, base_stop, base_dec, base_wrap;
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'(dut_vec()), 32'h0);
    check("reset_state", 32'(bus.state_dbg), 32'h0);
    at_drive_point();
    rst_n = 1'b1;

    // Breakpoint at 10 in free-run: counts 0..10 issued, then stop.
    base_ce = ce_total;
    bus.breakpoint = 4'd10;
    bus.run_en = 1'b1;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (bus.stop_req == 2'b11) break; end
    #1;
    check("bp_ce_cycles", 32'(ce_total - base_ce), 32'd11);
    check("bp_count", 32'(bus.cycle_count), 32'd10);
    check("bp_break_hit", 32'(bus.break_hit), 32'd1);
    check("bp_stop_req", 32'(bus.stop_req), 32'h3);

    // Acks arrive 3 cycles later, then reconfigure and release.
    repeat (3) at_drive_point();
    bus.stop_ack = 2'b11;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (bus.decouple) break; end
    #1;
    check("dec_decouple", 32'(bus.decouple), 32'd1);
    check("dec_ti_gnt", 32'(bus.ti_gnt), 32'd1);
    at_drive_point();
    bus.pr_done = 1'b1;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (!bus.decouple) break; end
    #1;
    check("rel_decouple", 32'(bus.decouple), 32'd0);
    check("rel_stop_req", 32'(bus.stop_req), 32'h0);
    at_drive_point();
    bus.pr_done = 1'b0;
    bus.stop_ack = 2'b00;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (!bus.busy) break; end
    #1;
    check("rel_idle", 32'(bus.state_dbg), 32'd0);
    base_ce = ce_total;
    repeat (10) @(negedge clk);
    #1;
    check("no_ce_after_break", 32'(ce_total - base_ce), 32'd0);

    // Single steps: three rising edges, the last held high.
    drive_idle();
    do_reset();
    base_ce = ce_total;
    for (int k = 0; k < 3; k++) begin
      at_drive_point();
      bus.step_req = 1'b1;
      repeat (k == 2 ? 10 : 2) at_drive_point();
      if (k != 2) bus.step_req = 1'b0;
      repeat (k == 2 ? 0 : 2) at_drive_point();
    end
    bus.step_req = 1'b0;
    @(negedge clk); #1;
    check("step_ce_pulses", 32'(ce_total - base_ce), 32'd3);
    check("step_count", 32'(bus.cycle_count), 32'd3);

    // Interruption with a partial ack set: both waits time out.
    drive_idle();
    do_reset();
    bus.run_en = 1'b1;
    repeat (4) at_drive_point();
    base_stop = stop_total; base_dec = dec_total;
    bus.ti_req = 1'b1; bus.run_en = 1'b0; bus.stop_ack = 2'b01;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (bus.stop_req == 2'b11) break; end
    at_drive_point();
    bus.ti_req = 1'b0;
    for (int i = 0; i < 30; i++) begin @(negedge clk); if (bus.timeout_err) break; end
    #1;
    check("to_err", 32'(bus.timeout_err), 32'd1);
    check("to_stop_req", 32'(bus.stop_req), 32'h0);
    for (int i = 0; i < 30; i++) begin @(negedge clk); if (!bus.busy) break; end
    #1;
    check("to_stop_cycles", 32'(stop_total - base_stop), 32'(ACK_T));
    check("to_no_decouple", 32'(dec_total - base_dec), 32'd0);
    check("to_idle", 32'(bus.state_dbg), 32'd0);
    repeat (5) @(negedge clk);
    check("to_err_sticky", 32'(bus.timeout_err), 32'd1);

    // Reset while decoupled clears everything at once.
    bus.ti_req = 1'b1; bus.stop_ack = 2'b11;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (bus.decouple) break; end
    check("pre_reset_decouple", 32'(bus.decouple), 32'd1);
    at_drive_point();
    bus.ti_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(dut_vec()), 32'h0);
    at_drive_point();
    rst_n = 1'b1;
    bus.stop_ack = 2'b00;
    @(negedge clk);
    check("post_reset_state", 32'(bus.state_dbg), 32'd0);

    // Counter wrap with the breakpoint disabled: 20 RUN cycles -> count 4.
    drive_idle();
    do_reset();
    base_ce = ce_total; base_stop = stop_total; base_wrap = wrap_total;
    bus.run_en = 1'b1;
    repeat (20) at_drive_point();
    bus.run_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("wrap_ce_cycles", 32'(ce_total - base_ce), 32'd20);
    check("wrap_count", 32'(bus.cycle_count), 32'd4);
    check("wrap_seen", 32'(wrap_total - base_wrap), 32'd1);
    check("wrap_no_stop", 32'(stop_total - base_stop), 32'd0);

    // Randomized traffic against the model.
    drive_idle();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      at_drive_point();
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        at_drive_point();
        rst_n = 1'b1;
      end
      bus.run_en   = ($urandom_range(0, 9) < 7);
      bus.step_req = ($urandom_range(0, 3) == 0) ? ~bus.step_req : bus.step_req;
      bus.ti_req   = ($urandom_range(0, 29) == 0);
      bus.pr_done  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) bus.breakpoint = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) bus.stop_ack = bus.stop_req;
      else bus.stop_ack = 2'($urandom_range(0, 3));
    end

    drive_idle();
    do_reset();
    repeat (2) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
